// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the half adder slice.
package half_adder_pkg;

  // Default width of the event counters.
  localparam int unsigned CNT_W_DEFAULT = 16;

  // Largest value a counter of the given width can hold (2^width - 1).
  // Computed at 64 bits so it also works for widths up to 64.
  function automatic logic [63:0] sat_max(input int unsigned width);
    if (width >= 64) begin
      return '1;
    end
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/ha_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
// clr wins over inc, so a sample arriving in the clear cycle is not counted.
module ha_sat_counter
  import half_adder_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(sat_max(CNT_W));

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Next count: clear first, then increment unless already pinned at the maximum.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CntMax)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/half_adder.sv
// Half adder with a combinational result, a registered copy of the last accepted
// sample, and two saturating event counters (all samples, samples producing a carry).
module half_adder
  import half_adder_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             in_valid,
  input  logic             clr,
  output logic             sum,
  output logic             carry,
  output logic             sum_q,
  output logic             carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] carry_cnt
);

  logic sum_d;
  logic carry_d;

  // Pure combinational half add; does not depend on clock, reset or qualifiers.
  always_comb begin
    sum   = a ^ b;
    carry = a & b;
  end

  // Result registers load only on an accepted sample and otherwise hold.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    if (in_valid) begin
      sum_d   = sum;
      carry_d = carry;
    end
  end

  // Registered result and valid; reset drops any in-flight out_valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= 1'b0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      out_valid <= in_valid;
    end
  end

  ha_sat_counter #(
    .CNT_W (CNT_W)
  ) u_sample_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (in_valid),
    .clr   (clr),
    .count (sample_cnt)
  );

  ha_sat_counter #(
    .CNT_W (CNT_W)
  ) u_carry_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (in_valid & carry),
    .clr   (clr),
    .count (carry_cnt)
  );

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: a default-width instance and a 2-bit-counter
// instance share all stimulus so saturation can be observed on the narrow one.
module tb_half_adder;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst;
  logic        a;
  logic        b;
  logic        in_valid;
  logic        clr;

  logic        sum, carry, sum_q, carry_q, out_valid;
  logic [15:0] sample_cnt, carry_cnt;

  logic        sum2, carry2, sum_q2, carry_q2, out_valid2;
  logic [1:0]  sample_cnt2, carry_cnt2;

  int          n_checks = 0;
  int          n_pass = 0;

  half_adder dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .in_valid   (in_valid),
    .clr        (clr),
    .sum        (sum),
    .carry      (carry),
    .sum_q      (sum_q),
    .carry_q    (carry_q),
    .out_valid  (out_valid),
    .sample_cnt (sample_cnt),
    .carry_cnt  (carry_cnt)
  );

  half_adder #(
    .CNT_W (2)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .in_valid   (in_valid),
    .clr        (clr),
    .sum        (sum2),
    .carry      (carry2),
    .sum_q      (sum_q2),
    .carry_q    (carry_q2),
    .out_valid  (out_valid2),
    .sample_cnt (sample_cnt2),
    .carry_cnt  (carry_cnt2)
  );

  always #5 clk = clk_en ? ~clk : 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] vec_ab  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic       vec_sum [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       vec_cy  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1;
    a = 1'b0;
    b = 1'b0;
    in_valid = 1'b0;
    clr = 1'b0;

    // Combinational truth table with no clock running and reset held.
    for (int i = 0; i < 4; i++) begin
      a = vec_ab[i][1];
      b = vec_ab[i][0];
      #10;
      check($sformatf("comb_sum_%0d", i), sum, vec_sum[i]);
      check($sformatf("comb_carry_%0d", i), carry, vec_cy[i]);
    end

    // Reset state, no clock edge seen yet.
    check("rst_sum_q", sum_q, 0);
    check("rst_carry_q", carry_q, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sample_cnt", sample_cnt, 0);
    check("rst_carry_cnt", carry_cnt, 0);

    // Samples offered during reset are not accepted.
    clk_en = 1'b1;
    a = 1'b1;
    b = 1'b1;
    in_valid = 1'b1;
    cycle();
    check("rst_hold_cnt", sample_cnt, 0);
    check("rst_hold_valid", out_valid, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    cycle();
    check("idle_valid", out_valid, 0);
    check("idle_cnt", sample_cnt, 0);

    // Single accepted 11 sample, then hold while inputs change.
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    a = 1'b0;
    b = 1'b0;
    check("one_sum_q", sum_q, 0);
    check("one_carry_q", carry_q, 1);
    check("one_out_valid", out_valid, 1);
    check("one_sample_cnt", sample_cnt, 1);
    check("one_carry_cnt", carry_cnt, 1);
    cycle();
    check("hold_out_valid", out_valid, 0);
    check("hold_sum_q", sum_q, 0);
    check("hold_carry_q", carry_q, 1);
    check("hold_sample_cnt", sample_cnt, 1);

    // Clear alone: counters zero, result registers untouched.
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("clr_sample_cnt", sample_cnt, 0);
    check("clr_carry_cnt", carry_cnt, 0);
    check("clr_carry_q", carry_q, 1);

    // Four back-to-back samples 00,01,10,11.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = vec_ab[i][1];
      b = vec_ab[i][0];
      cycle();
      check($sformatf("seq_sum_q_%0d", i), sum_q, vec_sum[i]);
      check($sformatf("seq_carry_q_%0d", i), carry_q, vec_cy[i]);
      check($sformatf("seq_valid_%0d", i), out_valid, 1);
    end
    in_valid = 1'b0;
    check("seq_sample_cnt", sample_cnt, 4);
    check("seq_carry_cnt", carry_cnt, 1);
    check("seq_sample_cnt_w2", sample_cnt2, 3);
    check("seq_carry_cnt_w2", carry_cnt2, 1);

    // Six 11 samples after a clear: narrow counters pin at 3.
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    a = 1'b1;
    b = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i == 2) begin
        check("sat3_sample_w2", sample_cnt2, 3);
        check("sat3_carry_w2", carry_cnt2, 3);
      end
    end
    in_valid = 1'b0;
    check("sat_sample_w2", sample_cnt2, 3);
    check("sat_carry_w2", carry_cnt2, 3);
    check("sat_sample_w16", sample_cnt, 6);
    check("sat_carry_w16", carry_cnt, 6);

    // Load 01 so the following clear-cycle sample visibly reloads the result.
    a = 1'b0;
    in_valid = 1'b1;
    cycle();
    check("pre_clr_sum_q", sum_q, 1);
    check("pre_clr_cnt", sample_cnt, 7);
    a = 1'b1;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    in_valid = 1'b0;
    check("clrinc_sample_cnt", sample_cnt, 0);
    check("clrinc_carry_cnt", carry_cnt, 0);
    check("clrinc_sum_q", sum_q, 0);
    check("clrinc_carry_q", carry_q, 1);
    check("clrinc_out_valid", out_valid, 1);

    // Build nonzero state with out_valid high, then reset between edges.
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_carry_cnt", carry_cnt, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_sum_q", sum_q, 0);
    check("mid_rst_carry_q", carry_q, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sample_cnt", sample_cnt, 0);
    check("mid_rst_carry_cnt", carry_cnt, 0);
    b = 1'b0;
    #1;
    check("mid_rst_comb_sum", sum, 1);
    check("mid_rst_comb_carry", carry, 0);

    // First acceptance after release.
    cycle();
    rst = 1'b0;
    b = 1'b1;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("post_rst_valid", out_valid, 1);
    check("post_rst_cnt", sample_cnt, 1);
    check("post_rst_carry_q", carry_q, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
